// File: rtl/mmc3_mapper.sv
// mmc3_mapper
// MMC3-class cartridge mapper: 8 KiB PRG banking, 1 KiB CHR banking,
// selectable nametable mirroring, PRG-RAM enable/write-protect and a
// scanline IRQ counter clocked by filtered PPU A12 rising edges.
//
// All state changes on the falling edge of m2 (CPU phi2). Reset is
// synchronous, active-high, sampled on that same edge.
//
// Ports:
//   m2          CPU phi2; state updates on its falling edge
//   reset       synchronous active-high reset
//   cpu_addr    CPU address bus
//   cpu_data_in CPU write data
//   cpu_rw      1 = CPU read, 0 = CPU write
//   ppu_addr    PPU address bus
//   ppu_rd      PPU read strobe, active-low
//   ppu_wr      PPU write strobe, active-low
//   args        cartridge configuration; args[6] = CHR RAM present
//   prg_addr    PRG ROM address {bank, cpu_addr[12:0]}
//   prg_oe      PRG ROM output enable
//   ram_ce      PRG-RAM select ($6000-$7FFF while RAM enabled)
//   ram_we      PRG-RAM write enable
//   chr_addr    CHR address {bank, ppu_addr[9:0]}
//   chr_ce      CHR chip enable (pattern table half of PPU space)
//   chr_oe      CHR output enable
//   chr_we      CHR write enable (only with CHR RAM)
//   ciram_ce    CIRAM chip enable
//   ciram_a10   CIRAM A10 (mirroring)
//   irq         level IRQ, active-high

module mmc3_mapper #(
    parameter int ADDR_BITS     = 23,
    parameter int PRG_BANK_BITS = 6,
    parameter int CHR_BANK_BITS = 8,
    parameter int A12_FILTER    = 3,
    parameter int IRQ_OLD       = 0
) (
    input  logic                 m2,
    input  logic                 reset,
    input  logic [15:0]          cpu_addr,
    input  logic [7:0]           cpu_data_in,
    input  logic                 cpu_rw,
    input  logic [13:0]          ppu_addr,
    input  logic                 ppu_rd,
    input  logic                 ppu_wr,
    input  logic [7:0]           args,
    output logic [ADDR_BITS-1:0] prg_addr,
    output logic                 prg_oe,
    output logic                 ram_ce,
    output logic                 ram_we,
    output logic [ADDR_BITS-1:0] chr_addr,
    output logic                 chr_ce,
    output logic                 chr_oe,
    output logic                 chr_we,
    output logic                 ciram_ce,
    output logic                 ciram_a10,
    output logic                 irq
);

    localparam logic [2:0] FILT = 3'(A12_FILTER);
    localparam logic [PRG_BANK_BITS-1:0] PRG_LAST        = '1;
    localparam logic [PRG_BANK_BITS-1:0] PRG_SECOND_LAST = {{(PRG_BANK_BITS-1){1'b1}}, 1'b0};

    // Register-file index: {cpu_addr[14:13], cpu_addr[0]}
    localparam logic [2:0] IDX_BANK_SEL  = 3'd0;  // $8000
    localparam logic [2:0] IDX_BANK_DATA = 3'd1;  // $8001
    localparam logic [2:0] IDX_MIRROR    = 3'd2;  // $A000
    localparam logic [2:0] IDX_RAM_PROT  = 3'd3;  // $A001
    localparam logic [2:0] IDX_IRQ_LATCH = 3'd4;  // $C000
    localparam logic [2:0] IDX_IRQ_RELOAD= 3'd5;  // $C001
    localparam logic [2:0] IDX_IRQ_OFF   = 3'd6;  // $E000
    localparam logic [2:0] IDX_IRQ_ON    = 3'd7;  // $E001

    // Bank control state
    logic [2:0]               sel;
    logic                     prg_mode;
    logic                     chr_inv;
    logic                     mirror;
    logic                     ram_en;
    logic                     ram_wp;
    logic [CHR_BANK_BITS-1:0] chr_bank [6];
    logic [PRG_BANK_BITS-1:0] prg_bank6;
    logic [PRG_BANK_BITS-1:0] prg_bank7;

    // IRQ state
    logic [7:0] irq_latch;
    logic [7:0] irq_counter;
    logic       irq_reload;
    logic       irq_en;
    logic       irq_pending;
    logic [2:0] lowcnt;

    // Write decode and IRQ next-state
    logic       reg_wr;
    logic [2:0] reg_idx;
    logic       a12_rise;
    logic       irq_reg_wr;
    logic       clk_evt;
    logic       irq_en_nxt;
    logic [7:0] cnt_upd;
    logic       fire;

    always_comb begin
        reg_wr     = cpu_addr[15] & ~cpu_rw;
        reg_idx    = {cpu_addr[14:13], cpu_addr[0]};
        a12_rise   = ppu_addr[12] && (lowcnt == FILT);
        // A $C000/$C001 write owns the counter on this edge; the A12 clock is lost.
        irq_reg_wr = reg_wr && (cpu_addr[14:13] == 2'b10);
        clk_evt    = a12_rise && !irq_reg_wr;

        irq_en_nxt = irq_en;
        if (reg_wr && reg_idx == IDX_IRQ_OFF) irq_en_nxt = 1'b0;
        if (reg_wr && reg_idx == IDX_IRQ_ON)  irq_en_nxt = 1'b1;

        if (irq_counter == 8'd0 || irq_reload) cnt_upd = irq_latch;
        else                                   cnt_upd = irq_counter - 8'd1;

        // Firing uses the enable as written on this same edge.
        fire = clk_evt && (cnt_upd == 8'd0) && irq_en_nxt &&
               ((IRQ_OLD == 0) || (irq_counter != 8'd0) || irq_reload);
    end

    always_ff @(negedge m2) begin
        if (reset) begin
            sel         <= '0;
            prg_mode    <= 1'b0;
            chr_inv     <= 1'b0;
            mirror      <= 1'b0;
            ram_en      <= 1'b0;
            ram_wp      <= 1'b0;
            for (int i = 0; i < 6; i++) chr_bank[i] <= '0;
            prg_bank6   <= '0;
            prg_bank7   <= '0;
            irq_latch   <= '0;
            irq_counter <= '0;
            irq_reload  <= 1'b0;
            irq_en      <= 1'b0;
            irq_pending <= 1'b0;
            lowcnt      <= '0;
        end else begin
            // A12 low-time filter
            if (!ppu_addr[12]) begin
                if (lowcnt != FILT) lowcnt <= lowcnt + 3'd1;
            end else begin
                lowcnt <= '0;
            end

            if (clk_evt) begin
                irq_counter <= cnt_upd;
                irq_reload  <= 1'b0;
            end

            irq_en <= irq_en_nxt;

            if (reg_wr && reg_idx == IDX_IRQ_OFF) irq_pending <= 1'b0;
            else if (fire)                        irq_pending <= 1'b1;

            if (reg_wr) begin
                case (reg_idx)
                    IDX_BANK_SEL: begin
                        sel      <= cpu_data_in[2:0];
                        prg_mode <= cpu_data_in[6];
                        chr_inv  <= cpu_data_in[7];
                    end
                    IDX_BANK_DATA: begin
                        case (sel)
                            3'd6:    prg_bank6 <= PRG_BANK_BITS'(cpu_data_in);
                            3'd7:    prg_bank7 <= PRG_BANK_BITS'(cpu_data_in);
                            default: chr_bank[sel] <= CHR_BANK_BITS'(cpu_data_in);
                        endcase
                    end
                    IDX_MIRROR:    mirror <= cpu_data_in[0];
                    IDX_RAM_PROT: begin
                        ram_en <= cpu_data_in[7];
                        ram_wp <= cpu_data_in[6];
                    end
                    IDX_IRQ_LATCH: irq_latch <= cpu_data_in;
                    IDX_IRQ_RELOAD: begin
                        irq_counter <= '0;
                        irq_reload  <= 1'b1;
                    end
                    default: ;  // $E000/$E001 handled through irq_en_nxt
                endcase
            end
        end
    end

    // PRG mapping
    logic [PRG_BANK_BITS-1:0] prg_bank;

    always_comb begin
        prg_bank = PRG_LAST;
        case (cpu_addr[14:13])
            2'd0:    prg_bank = prg_mode ? PRG_SECOND_LAST : prg_bank6;
            2'd1:    prg_bank = prg_bank7;
            2'd2:    prg_bank = prg_mode ? prg_bank6 : PRG_SECOND_LAST;
            default: prg_bank = PRG_LAST;
        endcase
    end

    assign prg_addr = ADDR_BITS'({prg_bank, cpu_addr[12:0]});
    assign prg_oe   = cpu_rw & cpu_addr[15];
    assign ram_ce   = (cpu_addr[15:13] == 3'b011) & ram_en;
    assign ram_we   = ram_ce & ~cpu_rw & ~ram_wp;

    // CHR mapping: chr_inv swaps the 2 KiB pair half with the 1 KiB half.
    logic [2:0]               chr_k;
    logic [CHR_BANK_BITS-1:0] chr_bank_cur;

    always_comb begin
        chr_k = ppu_addr[12:10] ^ {chr_inv, 2'b00};
        case (chr_k)
            3'd0, 3'd1: chr_bank_cur = {chr_bank[0][CHR_BANK_BITS-1:1], ppu_addr[10]};
            3'd2, 3'd3: chr_bank_cur = {chr_bank[1][CHR_BANK_BITS-1:1], ppu_addr[10]};
            3'd4:       chr_bank_cur = chr_bank[2];
            3'd5:       chr_bank_cur = chr_bank[3];
            3'd6:       chr_bank_cur = chr_bank[4];
            default:    chr_bank_cur = chr_bank[5];
        endcase
    end

    assign chr_addr  = ADDR_BITS'({chr_bank_cur, ppu_addr[9:0]});
    assign chr_ce    = ~ppu_addr[13];
    assign ciram_ce  = ~ppu_addr[13];
    assign chr_oe    = ~ppu_rd;
    assign chr_we    = args[6] & ~ppu_wr;
    assign ciram_a10 = mirror ? ppu_addr[11] : ppu_addr[10];

    assign irq = irq_pending;

    // Remaining config bits are reserved for other board variants.
    logic unused_args;
    assign unused_args = ^{args[7], args[5:0]};

endmodule

// File: tb/tb_mmc3_mapper.sv
// tb_mmc3_mapper
// Directed bench for mmc3_mapper. Two instances share every input: one with
// the "new" IRQ flavour, one with the "old". A transaction-level model kept
// here tracks what the CPU wrote and how many A12 rises occurred, and a
// compare process checks every output of both instances at each rising m2
// edge (half a cycle away from the falling edge that updates state).

module tb_mmc3_mapper;

    localparam int AB   = 23;
    localparam int PB   = 6;
    localparam int CB   = 8;
    localparam int FILT = 3;

    // ---------------------------------------------------------------- clock
    logic m2 = 1'b0;
    always #5 m2 = ~m2;

    // ----------------------------------------------------------- DUT wiring
    logic          reset;
    logic [15:0]   cpu_addr;
    logic [7:0]    cpu_data_in;
    logic          cpu_rw;
    logic [13:0]   ppu_addr;
    logic          ppu_rd;
    logic          ppu_wr;
    logic [7:0]    args;

    logic [AB-1:0] prg_addr, chr_addr, prg_addr_o, chr_addr_o;
    logic prg_oe, ram_ce, ram_we, chr_ce, chr_oe, chr_we, ciram_ce, ciram_a10, irq;
    logic prg_oe_o, ram_ce_o, ram_we_o, chr_ce_o, chr_oe_o, chr_we_o, ciram_ce_o, ciram_a10_o, irq_o;

    mmc3_mapper #(.ADDR_BITS(AB), .PRG_BANK_BITS(PB), .CHR_BANK_BITS(CB),
                  .A12_FILTER(FILT), .IRQ_OLD(0)) dut (
        .m2(m2), .reset(reset), .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in),
        .cpu_rw(cpu_rw), .ppu_addr(ppu_addr), .ppu_rd(ppu_rd), .ppu_wr(ppu_wr),
        .args(args), .prg_addr(prg_addr), .prg_oe(prg_oe), .ram_ce(ram_ce),
        .ram_we(ram_we), .chr_addr(chr_addr), .chr_ce(chr_ce), .chr_oe(chr_oe),
        .chr_we(chr_we), .ciram_ce(ciram_ce), .ciram_a10(ciram_a10), .irq(irq)
    );

    mmc3_mapper #(.ADDR_BITS(AB), .PRG_BANK_BITS(PB), .CHR_BANK_BITS(CB),
                  .A12_FILTER(FILT), .IRQ_OLD(1)) dut_old (
        .m2(m2), .reset(reset), .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in),
        .cpu_rw(cpu_rw), .ppu_addr(ppu_addr), .ppu_rd(ppu_rd), .ppu_wr(ppu_wr),
        .args(args), .prg_addr(prg_addr_o), .prg_oe(prg_oe_o), .ram_ce(ram_ce_o),
        .ram_we(ram_we_o), .chr_addr(chr_addr_o), .chr_ce(chr_ce_o), .chr_oe(chr_oe_o),
        .chr_we(chr_we_o), .ciram_ce(ciram_ce_o), .ciram_a10(ciram_a10_o), .irq(irq_o)
    );

    // ------------------------------------------------------------ scoreboard
    int n_checks = 0;
    int n_errors = 0;
    bit chk_on   = 1'b0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ----------------------------------------------------------------- model
    int m_r [8];
    int m_sel, m_latch, m_low;
    bit m_prg_mode, m_chr_inv, m_mirror, m_ram_en, m_ram_wp, m_irq_en;
    int m_cnt [2];      // [0] new flavour, [1] old flavour
    bit m_reload [2];
    bit m_pend [2];

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) m_r[i] = 0;
        m_sel = 0; m_latch = 0; m_low = 0;
        m_prg_mode = 0; m_chr_inv = 0; m_mirror = 0;
        m_ram_en = 0; m_ram_wp = 0; m_irq_en = 0;
        for (int f = 0; f < 2; f++) begin
            m_cnt[f] = 0; m_reload[f] = 0; m_pend[f] = 0;
        end
    endfunction

    // Applies the effect of one falling m2 edge with the current inputs.
    function automatic void model_edge();
        bit wr, rise, en_next;
        int idx, d;
        if (reset) begin
            model_reset();
            return;
        end
        wr  = cpu_addr[15] && !cpu_rw;
        idx = int'({cpu_addr[14:13], cpu_addr[0]});
        d   = int'(cpu_data_in);

        rise = 0;
        if (!ppu_addr[12]) begin
            if (m_low < FILT) m_low++;
        end else begin
            rise  = (m_low == FILT);
            m_low = 0;
        end

        en_next = m_irq_en;
        if (wr && idx == 6) en_next = 0;
        if (wr && idx == 7) en_next = 1;

        if (rise && !(wr && (idx == 4 || idx == 5))) begin
            for (int f = 0; f < 2; f++) begin
                int old_c, nv;
                bit rl;
                old_c = m_cnt[f];
                rl    = m_reload[f];
                nv    = (old_c == 0 || rl) ? m_latch : old_c - 1;
                m_cnt[f]    = nv;
                m_reload[f] = 0;
                if (nv == 0 && en_next && (f == 0 || old_c != 0 || rl)) m_pend[f] = 1;
            end
        end
        m_irq_en = en_next;

        if (wr) begin
            case (idx)
                0: begin m_sel = d % 8; m_prg_mode = d[6]; m_chr_inv = d[7]; end
                1: m_r[m_sel] = d;
                2: m_mirror = d[0];
                3: begin m_ram_en = d[7]; m_ram_wp = d[6]; end
                4: m_latch = d;
                5: for (int f = 0; f < 2; f++) begin m_cnt[f] = 0; m_reload[f] = 1; end
                6: for (int f = 0; f < 2; f++) m_pend[f] = 0;
                default: ;
            endcase
        end
    endfunction

    function automatic logic [31:0] exp_prg();
        int last, b;
        last = (1 << PB) - 1;
        case (cpu_addr[14:13])
            2'd0:    b = m_prg_mode ? last - 1 : m_r[6] % (1 << PB);
            2'd1:    b = m_r[7] % (1 << PB);
            2'd2:    b = m_prg_mode ? m_r[6] % (1 << PB) : last - 1;
            default: b = last;
        endcase
        return 32'(b * 8192 + int'(cpu_addr[12:0]));
    endfunction

    function automatic logic [31:0] exp_chr();
        int k, b;
        k = int'(ppu_addr[12:10]) ^ (m_chr_inv ? 4 : 0);
        if (k < 2)      b = (m_r[0] & 8'hFE) | int'(ppu_addr[10]);
        else if (k < 4) b = (m_r[1] & 8'hFE) | int'(ppu_addr[10]);
        else            b = m_r[k - 2];
        return 32'(b * 1024 + int'(ppu_addr[9:0]));
    endfunction

    // Compare process: both instances against the model, every cycle.
    always @(posedge m2) begin
        if (chk_on) begin
            cmp("prg_addr",  prg_addr,  exp_prg());
            cmp("prg_oe",    prg_oe,    cpu_rw & cpu_addr[15]);
            cmp("ram_ce",    ram_ce,    (cpu_addr[15:13] == 3'b011) & m_ram_en);
            cmp("ram_we",    ram_we,    (cpu_addr[15:13] == 3'b011) & m_ram_en & !cpu_rw & !m_ram_wp);
            cmp("chr_addr",  chr_addr,  exp_chr());
            cmp("chr_ce",    chr_ce,    !ppu_addr[13]);
            cmp("ciram_ce",  ciram_ce,  !ppu_addr[13]);
            cmp("chr_oe",    chr_oe,    !ppu_rd);
            cmp("chr_we",    chr_we,    args[6] & !ppu_wr);
            cmp("ciram_a10", ciram_a10, m_mirror ? ppu_addr[11] : ppu_addr[10]);
            cmp("irq_new",   irq,       m_pend[0]);
            cmp("prg_addr_o", prg_addr_o, exp_prg());
            cmp("chr_addr_o", chr_addr_o, exp_chr());
            cmp("strobes_o", {prg_oe_o, ram_ce_o, ram_we_o, chr_ce_o, chr_oe_o, chr_we_o, ciram_ce_o, ciram_a10_o},
                             {prg_oe, ram_ce, ram_we, chr_ce, chr_oe, chr_we, ciram_ce, ciram_a10});
            cmp("irq_old",   irq_o,     m_pend[1]);
        end
    end

    // --------------------------------------------------------------- drivers
    // One falling edge with the inputs as they stand, then step off the edge.
    task automatic tick();
        @(negedge m2);
        model_edge();
        #1;
    endtask

    task automatic cpu_idle();
        cpu_addr    = 16'h0000;
        cpu_rw      = 1'b1;
        cpu_data_in = 8'h00;
        ppu_rd      = 1'($urandom_range(0, 1));
        ppu_wr      = 1'($urandom_range(0, 1));
    endtask

    task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
        cpu_addr = a; cpu_rw = 1'b0; cpu_data_in = d;
        tick();
        cpu_idle();
    endtask

    // A12 held low for n_low samples, then one high sample; rests high.
    task automatic a12_rise(input int n_low);
        ppu_addr = 14'h0000;
        repeat (n_low) tick();
        ppu_addr = 14'h1000;
        tick();
    endtask

    // Clean low time, then a register write on the same edge A12 goes high.
    task automatic cpu_wr_rise(input logic [15:0] a, input logic [7:0] d);
        ppu_addr = 14'h0000;
        repeat (FILT) tick();
        ppu_addr = 14'h1000;
        cpu_addr = a; cpu_rw = 1'b0; cpu_data_in = d;
        tick();
        cpu_idle();
    endtask

    task automatic peek_prg(input string name, input logic [15:0] a, input logic [31:0] exp);
        cpu_addr = a; cpu_rw = 1'b1;
        #1;
        cmp(name, prg_addr, exp);
        cpu_idle();
    endtask

    task automatic peek_chr(input string name, input logic [13:0] pa, input logic [31:0] exp);
        ppu_addr = pa;
        #1;
        cmp(name, chr_addr, exp);
        ppu_addr = 14'h1000;
    endtask

    task automatic check_irq(input string name, input bit exp_new, input bit exp_old);
        cmp({name, "_new"}, irq,   exp_new);
        cmp({name, "_old"}, irq_o, exp_old);
    endtask

    // -------------------------------------------------------------- stimulus
    initial begin
        model_reset();
        reset    = 1'b1;
        args     = 8'h40;
        ppu_addr = 14'h1000;
        cpu_idle();
        tick();
        tick();
        reset  = 1'b0;
        chk_on = 1'b1;

        // Reset state
        check_irq("rst_irq", 1'b0, 1'b0);
        peek_prg("rst_prg8000", 16'h8000, 32'h00000);
        peek_prg("rst_prgE000", 16'hE000, 32'h7E000);
        peek_chr("rst_chr1400", 14'h1400, 32'h0);

        // PRG mode 0: R6=5, R7=9
        cpu_wr(16'h8000, 8'h06); cpu_wr(16'h8001, 8'h05);
        cpu_wr(16'h8000, 8'h07); cpu_wr(16'h8001, 8'h09);
        peek_prg("m0_slot0", 16'h8123, 32'h0A123);
        peek_prg("m0_slot1", 16'hA000, 32'h12000);
        peek_prg("m0_slot2", 16'hC000, 32'h7C000);
        peek_prg("m0_slot3", 16'hE000, 32'h7E000);

        // PRG mode 1
        cpu_wr(16'h8000, 8'h40);
        peek_prg("m1_slot0", 16'h8000, 32'h7C000);
        peek_prg("m1_slot1", 16'hA000, 32'h12000);
        peek_prg("m1_slot2", 16'hC000, 32'h0A000);
        peek_prg("m1_slot3", 16'hE000, 32'h7E000);

        // CHR inversion: R0=$13, R2=$20
        cpu_wr(16'h8000, 8'h80); cpu_wr(16'h8001, 8'h13);
        cpu_wr(16'h8000, 8'h82); cpu_wr(16'h8001, 8'h20);
        peek_chr("inv_chr1400", 14'h1400, 32'h4C00);
        peek_chr("inv_chr0000", 14'h0000, 32'h8000);

        // Mirroring and PRG RAM
        cpu_wr(16'hA000, 8'h01);
        ppu_addr = 14'h0800; #1;
        cmp("mirror_h", ciram_a10, 1'b1);
        ppu_addr = 14'h1000;
        cpu_wr(16'hA001, 8'hC0);
        cpu_addr = 16'h6000; cpu_rw = 1'b0; #1;
        cmp("ram_ce_wp", ram_ce, 1'b1);
        cmp("ram_we_wp", ram_we, 1'b0);
        tick(); cpu_idle();
        cpu_wr(16'hA001, 8'h80);
        cpu_addr = 16'h6000; cpu_rw = 1'b0; #1;
        cmp("ram_we_en", ram_we, 1'b1);
        tick(); cpu_idle();

        // Scanline IRQ, latch 3
        cpu_wr(16'hC000, 8'h03); cpu_wr(16'hC001, 8'h00); cpu_wr(16'hE001, 8'h00);
        a12_rise(3); check_irq("irq_r1", 0, 0);
        a12_rise(3); check_irq("irq_r2", 0, 0);
        a12_rise(3); check_irq("irq_r3", 0, 0);
        a12_rise(3); check_irq("irq_r4", 1, 1);
        cpu_wr(16'hE000, 8'h00); check_irq("irq_ack", 0, 0);

        // Short low time is ignored; counter still at 0
        cpu_wr(16'hE001, 8'h00);
        a12_rise(2); check_irq("short_rise", 0, 0);
        a12_rise(3); check_irq("flt_r1", 0, 0);
        a12_rise(3); check_irq("flt_r2", 0, 0);
        a12_rise(3); check_irq("flt_r3", 0, 0);
        a12_rise(3); check_irq("flt_r4", 1, 1);

        // latch 0: new flavour fires every rise, old only after $C001
        cpu_wr(16'hE000, 8'h00); cpu_wr(16'hC000, 8'h00);
        cpu_wr(16'hC001, 8'h00); cpu_wr(16'hE001, 8'h00);
        a12_rise(3); check_irq("l0_reload", 1, 1);
        for (int i = 0; i < 2; i++) begin
            cpu_wr(16'hE000, 8'h00); cpu_wr(16'hE001, 8'h00);
            a12_rise(3); check_irq("l0_repeat", 1, 0);
        end
        cpu_wr(16'hE000, 8'h00); cpu_wr(16'hE001, 8'h00); cpu_wr(16'hC001, 8'h00);
        a12_rise(3); check_irq("l0_after_c001", 1, 1);
        cpu_wr(16'hE000, 8'h00);

        // $C000 on a clock edge: the clock is dropped (counter stays 1)
        cpu_wr(16'hC000, 8'h02); cpu_wr(16'hC001, 8'h00); cpu_wr(16'hE001, 8'h00);
        a12_rise(3); a12_rise(3);
        cpu_wr_rise(16'hC000, 8'h07); check_irq("c000_drop", 0, 0);
        a12_rise(3); check_irq("c000_next", 1, 1);
        cpu_wr(16'hE000, 8'h00);

        // $C001 on a clock edge
        cpu_wr(16'hE001, 8'h00);
        cpu_wr_rise(16'hC001, 8'h00); check_irq("c001_drop", 0, 0);
        a12_rise(3); check_irq("c001_reload", 0, 0);

        // $E001 on a firing edge fires; $E000 on a firing edge does not
        cpu_wr(16'hE000, 8'h00); cpu_wr(16'hC000, 8'h01); cpu_wr(16'hC001, 8'h00);
        a12_rise(3);
        cpu_wr_rise(16'hE001, 8'h00); check_irq("e001_fire", 1, 1);
        cpu_wr(16'hE000, 8'h00); cpu_wr(16'hE001, 8'h00);
        a12_rise(3);
        cpu_wr_rise(16'hE000, 8'h00); check_irq("e000_block", 0, 0);

        // Reset while pending, with a bank write on the same edge
        cpu_wr(16'hE001, 8'h00); cpu_wr(16'hC000, 8'h00); cpu_wr(16'hC001, 8'h00);
        a12_rise(3); check_irq("pre_reset", 1, 1);
        reset = 1'b1;
        cpu_addr = 16'h8001; cpu_rw = 1'b0; cpu_data_in = 8'h55;
        tick();
        cpu_idle();
        check_irq("reset_irq", 0, 0);
        peek_prg("reset_prg8000", 16'h8000, 32'h00000);
        peek_chr("reset_chr1400", 14'h1400, 32'h0);
        peek_chr("reset_chr0000", 14'h0000, 32'h0);
        reset = 1'b0;
        tick();
        tick();

        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
